// File: rtl/cmd_phase_queue.sv
// Purpose: phase-gated FWFT command buffer; after a last-tagged command is popped the rest is held until i_phase_done.
// Latency: write-to-visible 1 cycle, release-to-visible 1 cycle, pop-to-next-head 0 cycles after the edge.
// Backpressure: o_full drops writes and sets sticky o_overflow; o_empty (empty or HOLD) makes i_read a no-op.
//
// Ports:
//   i_clk, i_rstn           clock, async active-low reset
//   i_write/i_data/i_last   write strobe, command word, end-of-phase tag
//   o_full, o_overflow      count == DEPTH, sticky write-while-full
//   i_read, o_data, o_empty issuer pop strobe, head word, head-not-available
//   i_phase_done, o_hold    release pulse from top, queue is in HOLD
//   o_phase, o_count        phases released so far, stored entries
module cmd_phase_queue #(
    parameter int WIDTH   = 64,
    parameter int DEPTH   = 512,
    parameter int PHASE_W = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_write,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_last,
    output logic                     o_full,
    output logic                     o_overflow,
    input  logic                     i_read,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_empty,
    input  logic                     i_phase_done,
    output logic                     o_hold,
    output logic [PHASE_W-1:0]       o_phase,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                release_en;

    logic [AW-1:0]       wptr;
    logic [AW-1:0]       rptr;
    logic [CW-1:0]       count;
    logic [PHASE_W-1:0]  phase;
    logic                overflow;

    // Each entry carries the command word plus its end-of-phase tag in the MSB.
    logic [WIDTH:0]      mem [DEPTH];
    logic [WIDTH:0]      head;
    logic                head_last;

    logic                full;
    logic                empty;
    logic                wr_en;
    logic                rd_en;

    assign head      = mem[rptr];
    assign head_last = head[WIDTH];

    assign full  = (count == CW'(DEPTH));
    // HOLD hides the head from the issuer even though entries are stored.
    assign empty = (count == '0) || (state == ST_HOLD);

    // A full queue drops the write even when a pop happens on the same edge.
    assign wr_en = i_write && !full;
    assign rd_en = i_read && !empty;

    // Phase FSM. In RUN a phase_done pulse is ignored, which also covers a
    // pulse coincident with the last-tagged pop: it belongs to the old phase.
    always_comb begin
        state_nxt  = state;
        release_en = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (rd_en && head_last) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (i_phase_done) begin
                    state_nxt  = ST_RUN;
                    release_en = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + AW'(1);
            end
            if (rd_en) begin
                rptr <= rptr + AW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            count <= '0;
        end else begin
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            overflow <= 1'b0;
        end else if (i_write && full) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            phase <= '0;
        end else if (release_en) begin
            phase <= phase + PHASE_W'(1);
        end
    end

    // Storage array carries no reset; stale contents are never observable
    // because o_data is forced to zero whenever the head is unavailable.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wptr] <= {i_last, i_data};
        end
    end

    assign o_full     = full;
    assign o_overflow = overflow;
    assign o_empty    = empty;
    assign o_data     = empty ? '0 : head[WIDTH-1:0];
    assign o_hold     = (state == ST_HOLD);
    assign o_phase    = phase;
    assign o_count    = count;

endmodule

// File: tb/tb_cmd_phase_queue.sv
module tb_cmd_phase_queue;

    localparam int W  = 16;
    localparam int D  = 4;
    localparam int PW = 8;

    logic                  i_clk;
    logic                  i_rstn;
    logic                  i_write;
    logic [W-1:0]          i_data;
    logic                  i_last;
    logic                  o_full;
    logic                  o_overflow;
    logic                  i_read;
    logic [W-1:0]          o_data;
    logic                  o_empty;
    logic                  i_phase_done;
    logic                  o_hold;
    logic [PW-1:0]         o_phase;
    logic [$clog2(D):0]    o_count;

    cmd_phase_queue #(.WIDTH(W), .DEPTH(D), .PHASE_W(PW)) dut (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_write      (i_write),
        .i_data       (i_data),
        .i_last       (i_last),
        .o_full       (o_full),
        .o_overflow   (o_overflow),
        .i_read       (i_read),
        .o_data       (o_data),
        .o_empty      (o_empty),
        .i_phase_done (i_phase_done),
        .o_hold       (o_hold),
        .o_phase      (o_phase),
        .o_count      (o_count)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Reference model: a plain queue of tagged words plus hold/phase/overflow flags.
    typedef struct packed {
        logic         last;
        logic [W-1:0] word;
    } ent_t;

    ent_t          mq[$];
    bit            m_hold;
    logic [PW-1:0] m_phase;
    bit            m_ovf;

    int n_asserts = 0;
    int n_fail    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit m_empty;
        m_empty = (mq.size() == 0) || m_hold;
        chk("count",    32'(o_count),    32'(mq.size()));
        chk("empty",    32'(o_empty),    32'(m_empty));
        chk("full",     32'(o_full),     32'(mq.size() == D));
        chk("overflow", 32'(o_overflow), 32'(m_ovf));
        chk("hold",     32'(o_hold),     32'(m_hold));
        chk("phase",    32'(o_phase),    32'(m_phase));
        if (!m_empty) begin
            chk("data", 32'(o_data), 32'(mq[0].word));
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic step(input bit w, input logic [W-1:0] d, input bit l,
                        input bit r, input bit pd);
        bit   m_full;
        bit   m_empty;
        bit   m_wr;
        bit   m_pop;
        ent_t h;
        i_write      = w;
        i_data       = d;
        i_last       = l;
        i_read       = r;
        i_phase_done = pd;
        m_full  = (mq.size() == D);
        m_empty = (mq.size() == 0) || m_hold;
        m_wr    = w && !m_full;
        m_pop   = r && !m_empty;
        @(posedge i_clk);
        #1;
        if (w && m_full) m_ovf = 1'b1;
        if (m_hold) begin
            if (pd) begin
                m_hold  = 1'b0;
                m_phase = m_phase + 1'b1;
            end
        end else if (m_pop) begin
            h = mq.pop_front();
            if (h.last) m_hold = 1'b1;
        end
        if (m_wr) mq.push_back({l, d});
        i_write      = 1'b0;
        i_read       = 1'b0;
        i_phase_done = 1'b0;
        i_last       = 1'b0;
        check_all();
    endtask

    task automatic model_reset();
        mq.delete();
        m_hold  = 1'b0;
        m_phase = '0;
        m_ovf   = 1'b0;
    endtask

    // Asynchronous reset asserted away from any edge, checked before a clock edge.
    task automatic do_reset();
        i_write      = 1'b0;
        i_read       = 1'b0;
        i_phase_done = 1'b0;
        i_last       = 1'b0;
        i_rstn       = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_data", 32'(o_data), 32'h0);
        @(negedge i_clk);
        i_rstn = 1'b1;
    endtask

    initial begin
        i_rstn       = 1'b1;
        i_write      = 1'b0;
        i_data       = '0;
        i_last       = 1'b0;
        i_read       = 1'b0;
        i_phase_done = 1'b0;
        model_reset();
        #2;
        do_reset();

        // Three writes then a mid-cycle reset.
        step(1, 16'h00A0, 0, 0, 0);
        step(1, 16'h00B0, 0, 0, 0);
        step(1, 16'h00C0, 1, 0, 0);
        chk("t1_count", 32'(o_count), 32'd3);
        chk("t1_empty", 32'(o_empty), 32'd0);
        chk("t1_data",  32'(o_data),  32'h00A0);
        #2;
        i_rstn = 1'b0;
        #1;
        chk("t1_rst_count", 32'(o_count), 32'd0);
        chk("t1_rst_empty", 32'(o_empty), 32'd1);
        do_reset();

        // Phase hold with continuous reads.
        step(1, 16'h000A, 0, 0, 0);
        step(1, 16'h000B, 0, 0, 0);
        step(1, 16'h000C, 1, 0, 0);
        step(1, 16'h000D, 0, 0, 0);
        chk("t2_head_a", 32'(o_data), 32'h000A);
        step(0, '0, 0, 1, 0);
        chk("t2_head_b", 32'(o_data), 32'h000B);
        step(1, 16'h000E, 0, 1, 0);
        chk("t2_head_c", 32'(o_data), 32'h000C);
        step(0, '0, 0, 1, 0);
        chk("t2_hold",  32'(o_hold),  32'd1);
        chk("t2_empty", 32'(o_empty), 32'd1);
        chk("t2_count", 32'(o_count), 32'd2);
        step(0, '0, 0, 1, 0);
        chk("t2_nopop", 32'(o_count), 32'd2);
        step(0, '0, 0, 0, 1);
        chk("t2_rel_empty", 32'(o_empty), 32'd0);
        chk("t2_rel_data",  32'(o_data),  32'h000D);
        chk("t2_rel_phase", 32'(o_phase), 32'd1);
        step(0, '0, 0, 1, 0);
        step(0, '0, 0, 1, 0);
        chk("t2_drained", 32'(o_count), 32'd0);

        // phase_done coincident with the last-tagged pop is ignored.
        do_reset();
        step(1, 16'h0F00, 0, 0, 0);
        step(1, 16'h0C00, 1, 0, 0);
        step(0, '0, 0, 1, 0);
        step(0, '0, 0, 1, 1);
        chk("t3_hold",  32'(o_hold),  32'd1);
        chk("t3_phase", 32'(o_phase), 32'd0);
        step(0, '0, 0, 0, 1);
        chk("t3_rel_hold",  32'(o_hold),  32'd0);
        chk("t3_rel_phase", 32'(o_phase), 32'd1);
        chk("t3_rel_empty", 32'(o_empty), 32'd1);

        // Overflow: five writes into a four-entry queue.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(1, 16'h1000 + 16'(k), 0, 0, 0);
            if (k == 3) chk("t4_full", 32'(o_full), 32'd1);
        end
        chk("t4_overflow", 32'(o_overflow), 32'd1);
        chk("t4_count",    32'(o_count),    32'd4);
        for (int k = 0; k < 4; k++) begin
            chk("t4_readback", 32'(o_data), 32'h1000 + 32'(k));
            step(0, '0, 0, 1, 0);
        end
        chk("t4_empty", 32'(o_empty), 32'd1);

        // Steady-state read+write at count 2, wrapping the pointers.
        do_reset();
        step(1, 16'h2000, 0, 0, 0);
        step(1, 16'h2001, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            chk("t5_seq", 32'(o_data), 32'h2000 + 32'(k));
            step(1, 16'h2002 + 16'(k), 0, 1, 0);
            chk("t5_count", 32'(o_count), 32'd2);
        end

        // Write and read on an empty queue.
        do_reset();
        step(1, 16'h3333, 0, 1, 0);
        chk("t6_count", 32'(o_count), 32'd1);
        chk("t6_empty", 32'(o_empty), 32'd0);
        chk("t6_data",  32'(o_data),  32'h3333);

        // Random traffic against the model.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 1) == 1),
                 W'($urandom),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
